// File: rtl/me_pixel_feeder.sv
// Pixel feeder for the ME core: arbitrates cur/ref beat requests onto two byte-wide frame memories
// and packs sequential pixels into wide beats. Optional statistics counters under ME_FEED_STATS_EN.
module me_pixel_feeder #(
  parameter int PIX_W     = 8,
  parameter int CUR_PIX   = 4,
  parameter int REF_PIX   = 8,
  parameter int CUR_AW    = 24,
  parameter int REF_AW    = 26,
  parameter int CUR_DEPTH = 8294400,
  parameter int REF_DEPTH = 23945760,
  parameter int MEM_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     need_cur,
  input  logic                     need_ref,
  input  logic                     arb_mode,
  input  logic                     soft_clr,
  output logic                     cur_rd_en,
  output logic [CUR_AW-1:0]        cur_rd_addr,
  input  logic [PIX_W-1:0]         cur_rd_data,
  output logic                     ref_rd_en,
  output logic [REF_AW-1:0]        ref_rd_addr,
  input  logic [PIX_W-1:0]         ref_rd_data,
  output logic [CUR_PIX*PIX_W-1:0] cur_in,
  output logic                     cur_vld,
  output logic [REF_PIX*PIX_W-1:0] ref_in,
  output logic                     ref_vld,
  output logic                     cur_wrap,
  output logic                     ref_wrap
`ifdef ME_FEED_STATS_EN
  ,
  output logic [31:0]              stat_cur_beats,
  output logic [31:0]              stat_ref_beats,
  output logic [31:0]              stat_stall
`endif
);

  localparam int MAX_PIX = (CUR_PIX > REF_PIX) ? CUR_PIX : REF_PIX;
  localparam int CNT_W   = $clog2(MAX_PIX + 1);
  localparam int CUR_W   = CUR_PIX * PIX_W;
  localparam int REF_W   = REF_PIX * PIX_W;
  localparam int PACK_W  = MAX_PIX * PIX_W;

  typedef enum logic [1:0] {IDLE, CUR_BURST, REF_BURST, DRAIN} state_e;
  typedef enum logic {CH_CUR = 1'b0, CH_REF = 1'b1} chan_e;

  state_e              state_q, state_d;
  chan_e               chan_q, chan_d, rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cap_q, cap_d, last_cap;
  logic [MEM_LAT-1:0]  tag_q, tag_d;
  logic [CUR_AW-1:0]   cur_addr_q, cur_addr_d;
  logic [REF_AW-1:0]   ref_addr_q, ref_addr_d;
  logic                cur_wpend_q, cur_wpend_d, ref_wpend_q, ref_wpend_d;
  logic                clr_pend_q, clr_pend_d;
  logic [PACK_W-1:0]   pack_q, pack_d;
  logic [CUR_W-1:0]    cur_in_q, cur_in_d;
  logic [REF_W-1:0]    ref_in_q, ref_in_d;
  logic                cur_vld_q, cur_vld_d, ref_vld_q, ref_vld_d;
  logic [PIX_W-1:0]    rd_data;
  logic                done, clr_now;

  assign cur_rd_en   = (state_q == CUR_BURST);
  assign ref_rd_en   = (state_q == REF_BURST);
  assign cur_rd_addr = cur_addr_q;
  assign ref_rd_addr = ref_addr_q;
  // A wrap is flagged on the first strobe after the counter rolled over, not on every address 0.
  assign cur_wrap    = cur_rd_en & cur_wpend_q;
  assign ref_wrap    = ref_rd_en & ref_wpend_q;
  assign cur_in      = cur_in_q;
  assign ref_in      = ref_in_q;
  assign cur_vld     = cur_vld_q;
  assign ref_vld     = ref_vld_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    chan_d      = chan_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    tag_d       = MEM_LAT'({tag_q, cur_rd_en | ref_rd_en});
    cur_addr_d  = cur_addr_q;
    ref_addr_d  = ref_addr_q;
    cur_wpend_d = cur_wpend_q;
    ref_wpend_d = ref_wpend_q;
    clr_pend_d  = clr_pend_q;
    pack_d      = pack_q;
    cur_in_d    = cur_in_q;
    ref_in_d    = ref_in_q;
    cur_vld_d   = 1'b0;
    ref_vld_d   = 1'b0;
    rd_data     = (chan_q == CH_REF) ? ref_rd_data : cur_rd_data;
    last_cap    = (chan_q == CH_REF) ? CNT_W'(REF_PIX - 1) : CNT_W'(CUR_PIX - 1);

    // Returning data is tagged by the delayed strobe, so capture is independent of FSM state.
    if (tag_q[MEM_LAT-1]) begin
      pack_d[int'(cap_q)*PIX_W +: PIX_W] = rd_data;
      cap_d = cap_q + 1'b1;
    end
    done = (state_q == DRAIN) && tag_q[MEM_LAT-1] && (cap_q == last_cap);

    if (soft_clr && state_q != IDLE) clr_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (need_cur && (!need_ref || !arb_mode || rr_q == CH_CUR)) begin
          state_d = CUR_BURST;
          chan_d  = CH_CUR;
        end else if (need_ref) begin
          state_d = REF_BURST;
          chan_d  = CH_REF;
        end
      end
      CUR_BURST: begin
        cur_wpend_d = 1'b0;
        if (cur_addr_q == CUR_AW'(CUR_DEPTH - 1)) begin
          cur_addr_d  = '0;
          cur_wpend_d = 1'b1;
        end else begin
          cur_addr_d = cur_addr_q + 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CUR_PIX - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      REF_BURST: begin
        ref_wpend_d = 1'b0;
        if (ref_addr_q == REF_AW'(REF_DEPTH - 1)) begin
          ref_addr_d  = '0;
          ref_wpend_d = 1'b1;
        end else begin
          ref_addr_d = ref_addr_q + 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(REF_PIX - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = IDLE;
          cap_d   = '0;
          rr_d    = (chan_q == CH_CUR) ? CH_REF : CH_CUR;
          if (chan_q == CH_CUR) begin
            cur_in_d  = pack_d[CUR_W-1:0];
            cur_vld_d = 1'b1;
          end else begin
            ref_in_d  = pack_d[REF_W-1:0];
            ref_vld_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clears land between bursts only, so an in-flight burst keeps its original addresses.
    clr_now = (state_q == IDLE && soft_clr) || (done && (clr_pend_q || soft_clr));
    if (clr_now) begin
      cur_addr_d  = '0;
      ref_addr_d  = '0;
      cur_wpend_d = 1'b0;
      ref_wpend_d = 1'b0;
      clr_pend_d  = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      chan_q      <= CH_CUR;
      rr_q        <= CH_CUR;
      cnt_q       <= '0;
      cap_q       <= '0;
      tag_q       <= '0;
      cur_addr_q  <= '0;
      ref_addr_q  <= '0;
      cur_wpend_q <= 1'b0;
      ref_wpend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      // NOTE: the pack register is small, so it is reset like any other flop rather than left as storage.
      pack_q      <= '0;
      cur_in_q    <= '0;
      ref_in_q    <= '0;
      cur_vld_q   <= 1'b0;
      ref_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      tag_q       <= tag_d;
      cur_addr_q  <= cur_addr_d;
      ref_addr_q  <= ref_addr_d;
      cur_wpend_q <= cur_wpend_d;
      ref_wpend_q <= ref_wpend_d;
      clr_pend_q  <= clr_pend_d;
      pack_q      <= pack_d;
      cur_in_q    <= cur_in_d;
      ref_in_q    <= ref_in_d;
      cur_vld_q   <= cur_vld_d;
      ref_vld_q   <= ref_vld_d;
    end
  end

`ifdef ME_FEED_STATS_EN
  logic [31:0] st_cur_q, st_cur_d, st_ref_q, st_ref_d, st_stall_q, st_stall_d;

  always_comb begin
    st_cur_d   = st_cur_q;
    st_ref_d   = st_ref_q;
    st_stall_d = st_stall_q;
    if (cur_vld_q && st_cur_q != '1) st_cur_d = st_cur_q + 1'b1;
    if (ref_vld_q && st_ref_q != '1) st_ref_d = st_ref_q + 1'b1;
    if ((need_cur || need_ref) && state_q != IDLE && st_stall_q != '1) st_stall_d = st_stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cur_q   <= '0;
      st_ref_q   <= '0;
      st_stall_q <= '0;
    end else begin
      st_cur_q   <= st_cur_d;
      st_ref_q   <= st_ref_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_cur_beats = st_cur_q;
  assign stat_ref_beats = st_ref_q;
  assign stat_stall     = st_stall_q;
`endif

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Bench for me_pixel_feeder: two instances (default, and small-depth/MEM_LAT=3) share stimulus and
// are compared every cycle against a schedule-based reference model of bursts, beats and wraps.
module tb_me_pixel_feeder;

  localparam int MAXC = 2200;

  logic clk = 1'b0;
  logic rst, need_cur, need_ref, arb_mode, soft_clr;

  logic        cur_rd_en_a, ref_rd_en_a, cur_vld_a, ref_vld_a, cur_wrap_a, ref_wrap_a;
  logic [23:0] cur_rd_addr_a;
  logic [25:0] ref_rd_addr_a;
  logic [7:0]  cur_rd_data_a, ref_rd_data_a;
  logic [31:0] cur_in_a;
  logic [63:0] ref_in_a;

  logic        cur_rd_en_b, ref_rd_en_b, cur_vld_b, ref_vld_b, cur_wrap_b, ref_wrap_b;
  logic [23:0] cur_rd_addr_b;
  logic [25:0] ref_rd_addr_b;
  logic [7:0]  cur_rd_data_b, ref_rd_data_b;
  logic [31:0] cur_in_b;
  logic [63:0] ref_in_b;

  always #5 clk = ~clk;

  me_pixel_feeder u_a (
    .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref), .arb_mode(arb_mode),
    .soft_clr(soft_clr), .cur_rd_en(cur_rd_en_a), .cur_rd_addr(cur_rd_addr_a),
    .cur_rd_data(cur_rd_data_a), .ref_rd_en(ref_rd_en_a), .ref_rd_addr(ref_rd_addr_a),
    .ref_rd_data(ref_rd_data_a), .cur_in(cur_in_a), .cur_vld(cur_vld_a), .ref_in(ref_in_a),
    .ref_vld(ref_vld_a), .cur_wrap(cur_wrap_a), .ref_wrap(ref_wrap_a)
  );

  me_pixel_feeder #(.CUR_DEPTH(6), .REF_DEPTH(10), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref), .arb_mode(arb_mode),
    .soft_clr(soft_clr), .cur_rd_en(cur_rd_en_b), .cur_rd_addr(cur_rd_addr_b),
    .cur_rd_data(cur_rd_data_b), .ref_rd_en(ref_rd_en_b), .ref_rd_addr(ref_rd_addr_b),
    .ref_rd_data(ref_rd_data_b), .cur_in(cur_in_b), .cur_vld(cur_vld_b), .ref_in(ref_in_b),
    .ref_vld(ref_vld_b), .cur_wrap(cur_wrap_b), .ref_wrap(ref_wrap_b)
  );

  // Frame memories: byte = address[7:0], valid MEM_LAT cycles after the strobe, random otherwise.
  logic       ca_v = 1'b0, ra_v = 1'b0;
  logic [7:0] ca_a = '0, ra_a = '0, ca_j = '0, ra_j = '0;
  logic [2:0] cb_v = '0, rb_v = '0;
  logic [23:0] cb_a = '0, rb_a = '0;
  logic [7:0] cb_j = '0, rb_j = '0;

  always @(posedge clk) begin
    ca_v <= cur_rd_en_a;  ca_a <= cur_rd_addr_a[7:0];  ca_j <= 8'($urandom);
    ra_v <= ref_rd_en_a;  ra_a <= ref_rd_addr_a[7:0];  ra_j <= 8'($urandom);
    cb_v <= {cb_v[1:0], cur_rd_en_b};  cb_a <= {cb_a[15:0], cur_rd_addr_b[7:0]};  cb_j <= 8'($urandom);
    rb_v <= {rb_v[1:0], ref_rd_en_b};  rb_a <= {rb_a[15:0], ref_rd_addr_b[7:0]};  rb_j <= 8'($urandom);
  end

  assign cur_rd_data_a = ca_v ? ca_a : ca_j;
  assign ref_rd_data_a = ra_v ? ra_a : ra_j;
  assign cur_rd_data_b = cb_v[2] ? cb_a[23:16] : cb_j;
  assign ref_rd_data_b = rb_v[2] ? rb_a[23:16] : rb_j;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // Reference model: expected events per [instance][channel][cycle]
  bit          e_en   [2][2][MAXC];
  int          e_addr [2][2][MAXC];
  bit          e_wrap [2][2][MAXC];
  bit          e_vld  [2][2][MAXC];
  logic [63:0] e_beat [2][2][MAXC];

  int          busy_until [2];
  int          m_addr     [2][2];
  bit          m_wrapped  [2][2];
  int          m_ptr      [2];
  bit          m_pend     [2];
  logic [63:0] m_hold     [2][2];
  int          depth      [2][2] = '{'{8294400, 23945760}, '{6, 10}};
  int          lat        [2]    = '{1, 3};
  int          npix       [2]    = '{4, 8};
  int          cyc;

  task automatic model_reset(input int from);
    for (int i = 0; i < 2; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int t = from; t < MAXC; t++) begin
          e_en[i][ch][t] = 0; e_wrap[i][ch][t] = 0; e_vld[i][ch][t] = 0;
        end
        m_addr[i][ch] = 0; m_wrapped[i][ch] = 0; m_hold[i][ch] = '0;
      end
      busy_until[i] = 0; m_ptr[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit nc, input bit nr, input bit arb, input bit clr);
    int ch;
    int t;
    int v;
    logic [63:0] beat;
    if (cyc < busy_until[i]) begin
      if (clr) m_pend[i] = 1;
      return;
    end
    if (m_pend[i] || clr) begin
      for (int c = 0; c < 2; c++) begin m_addr[i][c] = 0; m_wrapped[i][c] = 0; end
      m_pend[i] = 0;
    end
    ch = -1;
    if (nc && (!nr || !arb || m_ptr[i] == 0)) ch = 0;
    else if (nr) ch = 1;
    if (ch < 0) return;
    beat = '0;
    for (int k = 0; k < npix[ch]; k++) begin
      t = cyc + 1 + k;
      e_en[i][ch][t]   = 1;
      e_addr[i][ch][t] = m_addr[i][ch];
      e_wrap[i][ch][t] = m_wrapped[i][ch];
      m_wrapped[i][ch] = 0;
      beat[k*8 +: 8]   = 8'(m_addr[i][ch]);
      if (m_addr[i][ch] == depth[i][ch] - 1) begin
        m_addr[i][ch] = 0; m_wrapped[i][ch] = 1;
      end else begin
        m_addr[i][ch]++;
      end
    end
    v = cyc + npix[ch] + lat[i] + 1;
    e_vld[i][ch][v]  = 1;
    e_beat[i][ch][v] = beat;
    busy_until[i]    = v;
    m_ptr[i]         = 1 - ch;
  endtask

  task automatic compare_inst(input int i, input logic [5:0] flags, input logic [63:0] caddr,
                              input logic [63:0] raddr, input logic [63:0] cin, input logic [63:0] rin);
    logic [5:0] ef;
    for (int ch = 0; ch < 2; ch++)
      if (e_vld[i][ch][cyc]) m_hold[i][ch] = e_beat[i][ch][cyc];
    ef = {e_en[i][0][cyc], e_en[i][1][cyc], e_vld[i][0][cyc], e_vld[i][1][cyc],
          e_wrap[i][0][cyc], e_wrap[i][1][cyc]};
    check($sformatf("i%0d.flags@%0d", i, cyc), {58'd0, flags}, {58'd0, ef});
    if (e_en[i][0][cyc]) check($sformatf("i%0d.cur_addr@%0d", i, cyc), caddr, 64'(e_addr[i][0][cyc]));
    if (e_en[i][1][cyc]) check($sformatf("i%0d.ref_addr@%0d", i, cyc), raddr, 64'(e_addr[i][1][cyc]));
    check($sformatf("i%0d.cur_in@%0d", i, cyc), cin, m_hold[i][0]);
    check($sformatf("i%0d.ref_in@%0d", i, cyc), rin, m_hold[i][1]);
  endtask

  task automatic run_cycle(input bit r, input bit nc, input bit nr, input bit arb, input bit clr);
    @(posedge clk);
    #1;
    rst = r; need_cur = nc; need_ref = nr; arb_mode = arb; soft_clr = clr;
    cyc++;
    if (r) model_reset(cyc);
    @(negedge clk);
    compare_inst(0, {cur_rd_en_a, ref_rd_en_a, cur_vld_a, ref_vld_a, cur_wrap_a, ref_wrap_a},
                 64'(cur_rd_addr_a), 64'(ref_rd_addr_a), 64'(cur_in_a), ref_in_a);
    compare_inst(1, {cur_rd_en_b, ref_rd_en_b, cur_vld_b, ref_vld_b, cur_wrap_b, ref_wrap_b},
                 64'(cur_rd_addr_b), 64'(ref_rd_addr_b), 64'(cur_in_b), ref_in_b);
    if (!r) begin
      model_step(0, nc, nr, arb, clr);
      model_step(1, nc, nr, arb, clr);
    end
  endtask

  initial begin
    int cnt_cur, cnt_ref;
    int seq[$];
    bit arb_r;
    rst = 1'b1; need_cur = 1'b0; need_ref = 1'b0; arb_mode = 1'b0; soft_clr = 1'b0;
    cyc = -1;
    model_reset(0);

    repeat (3) run_cycle(1, 0, 0, 0, 0);
    check("rst_outputs", {58'd0, cur_rd_en_a, ref_rd_en_a, cur_vld_a, ref_vld_a, cur_in_a[0], ref_in_a[0]}, 64'd0);

    // need_cur held: beats 0x03020100 / 0x07060504; small-depth instance wraps on its second beat
    for (int k = 0; k < 20; k++) begin
      run_cycle(0, 1, 0, 0, 0);
      if (k == 1)  check("tp1_first_read", {cur_rd_en_a, 24'(cur_rd_addr_a)}, {1'b1, 24'd0});
      if (k == 6)  check("tp1_beat0", {31'd0, cur_vld_a, cur_in_a}, {31'd0, 1'b1, 32'h03020100});
      if (k == 12) check("tp1_beat1", {31'd0, cur_vld_a, cur_in_a}, {31'd0, 1'b1, 32'h07060504});
      if (k == 11) check("tp4_wrap_b", {cur_wrap_b, cur_rd_addr_b}, {1'b1, 24'd0});
      if (k == 16) check("tp4_beat1_b", {31'd0, cur_vld_b, cur_in_b}, {31'd0, 1'b1, 32'h01000504});
    end

    // need_ref only
    repeat (2) run_cycle(1, 0, 0, 0, 0);
    cnt_cur = 0; cnt_ref = 0;
    for (int k = 0; k < 11; k++) begin
      run_cycle(0, 0, 1, 0, 0);
      cnt_cur += int'(cur_rd_en_a);
      cnt_ref += int'(ref_rd_en_a);
      if (k == 10) check("tp2_ref_beat", ref_vld_a ? ref_in_a : 64'd0, 64'h0706050403020100);
    end
    check("tp2_ref_reads", 64'(cnt_ref), 64'd8);
    check("tp2_no_cur_reads", 64'(cnt_cur), 64'd0);

    // both held, fixed priority: cur only
    repeat (2) run_cycle(1, 0, 0, 0, 0);
    cnt_ref = 0;
    for (int k = 0; k < 30; k++) begin
      run_cycle(0, 1, 1, 0, 0);
      cnt_ref += int'(ref_rd_en_a);
    end
    check("tp3_fixed_no_ref", 64'(cnt_ref), 64'd0);

    // both held, round-robin: cur, ref, cur, ref
    repeat (2) run_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      run_cycle(0, 1, 1, 1, 0);
      if (cur_vld_a) seq.push_back(0);
      if (ref_vld_a) seq.push_back(1);
    end
    check("tp3_rr_nbeats", 64'(seq.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && k < seq.size(); k++)
      check($sformatf("tp3_rr_order%0d", k), 64'(seq[k]), 64'(k % 2));

    // soft_clr in the second cycle of the second cur burst
    repeat (2) run_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      run_cycle(0, 1, 0, 0, k == 8);
      if (k == 12) check("tp5_beat_unaffected", 64'(cur_in_a), 64'h07060504);
      if (k == 13) check("tp5_restart0", {cur_rd_en_a, cur_rd_addr_a}, {1'b1, 24'd0});
    end

    // reset in the third cycle of a MEM_LAT=3 burst
    repeat (2) run_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) run_cycle(0, 1, 0, 0, 0);
    run_cycle(1, 1, 0, 0, 0);
    check("tp6_rst_outputs", {cur_rd_en_b, cur_vld_b, cur_rd_addr_b, cur_in_b}, '0);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 1, 0, 0, 0);
    check("tp6_restart0", {cur_rd_en_b, cur_rd_addr_b}, {1'b1, 24'd0});
    repeat (12) run_cycle(0, 1, 0, 0, 0);

    // randomized traffic
    arb_r = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) arb_r = ~arb_r;
      run_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                arb_r, $urandom_range(0, 29) == 0);
    end
    repeat (20) run_cycle(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/me_pixel_feeder.md
Name: me_pixel_feeder

Overview:
- Parametrised pixel feeder for the ME core. Arbitrates the core's need_cur / need_ref requests onto two byte-wide frame memories and packs N sequential pixels per channel into one wide beat (cur_in / ref_in).
- Successor of the single-byte, cur-first feeder. Adds configurable beat widths, memory read latency, round-robin arbitration, frame wrap and a soft address clear.

Parameters:
- PIX_W, 8, bits per pixel
- CUR_PIX, 4, pixels per cur beat (cur_in width = CUR_PIX*PIX_W)
- REF_PIX, 8, pixels per ref beat (ref_in width = REF_PIX*PIX_W)
- CUR_AW, 24, cur address width
- REF_AW, 26, ref address width
- CUR_DEPTH, 8294400, cur frame size in pixels (wrap point)
- REF_DEPTH, 23945760, ref frame size in pixels (wrap point)
- MEM_LAT, 1, fixed memory read latency in cycles (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- need_cur  in  1  core requests one cur beat
- need_ref  in  1  core requests one ref beat
- arb_mode  in  1  0 = fixed cur priority, 1 = round-robin
- soft_clr  in  1  one-cycle pulse; zero both address counters
- cur_rd_en  out  1  cur memory read strobe
- cur_rd_addr  out  CUR_AW  cur memory address
- cur_rd_data  in  PIX_W  cur memory data, valid MEM_LAT cycles after strobe
- ref_rd_en  out  1  ref memory read strobe
- ref_rd_addr  out  REF_AW  ref memory address
- ref_rd_data  in  PIX_W  ref memory data
- cur_in  out  CUR_PIX*PIX_W  packed cur beat
- cur_vld  out  1  one-cycle pulse: cur_in updated
- ref_in  out  REF_PIX*PIX_W  packed ref beat
- ref_vld  out  1  one-cycle pulse: ref_in updated
- cur_wrap  out  1  pulse when cur address wraps to 0
- ref_wrap  out  1  pulse when ref address wraps to 0

Behaviour:
- Reset: all outputs 0, both address counters 0, FSM in IDLE, round-robin pointer = cur, soft_clr pending flag cleared. Reset mid-burst aborts the burst; no vld is emitted.
- FSM states: IDLE, CUR_BURST, REF_BURST, DRAIN.
- IDLE, grant:
  - Only need_cur: go to CUR_BURST.
  - Only need_ref: go to REF_BURST.
  - Both, arb_mode=0: cur wins.
  - Both, arb_mode=1: channel not served by the last completed burst wins. The pointer updates on burst completion.
- Burst: issue one read per cycle for exactly CUR_PIX (REF_PIX) consecutive cycles, rd_en=1, address incrementing by 1, then go to DRAIN.
  - A burst is uninterruptible; need_* deassertion mid-burst is ignored.
  - The other channel's rd_en stays 0.
- DRAIN: wait until the last read's data returns (MEM_LAT cycles after the last strobe).
  - The packed beat is then registered into cur_in/ref_in and vld pulses for one cycle.
  - The FSM returns to IDLE in the vld cycle.
- Packing: pixel k of a burst (k=0 first read) lands at bits [k*PIX_W +: PIX_W]. Data is captured via a MEM_LAT-deep strobe-tag shift pipeline.
- Latency: if grant is decided in cycle 0, reads occur in cycles 1..N and vld occurs in cycle N+MEM_LAT+1. With CUR_PIX=4 and MEM_LAT=1, cur_vld is in cycle 6. IDLE re-arbitrates in the vld cycle, so the next burst's first read is in cycle N+MEM_LAT+2.
- Wrap: address DEPTH-1 is followed by 0 inside a burst, with no gap. The wrap pulse coincides with the read strobe at address 0.
- soft_clr:
  - In IDLE: both counters go to 0 on the next edge.
  - During a burst or DRAIN: latched as pending and applied on the vld cycle edge. The current burst completes with its original addresses.
  - A grant in that same IDLE cycle uses address 0.
- cur_in/ref_in hold their value between vld pulses.

Optional Feature:
- ME_FEED_STATS_EN. When defined, the block adds three outputs, all zeroed by rst:
  - stat_cur_beats (32 bits): counts cur_vld pulses.
  - stat_ref_beats (32 bits): counts ref_vld pulses.
  - stat_stall (32 bits): counts cycles where any need_* is high while the FSM is not in IDLE.
- All three counters saturate at 0xFFFFFFFF.
- When the macro is undefined, these ports and their logic are absent. Functional behaviour is identical either way.

Test Plan:
- Reset then need_cur held high, memory byte = address[7:0], defaults -> reads at addr 0..3 in cycles 1-4; cur_vld in cycle 6 with cur_in=0x03020100; second beat cur_in=0x07060504.
- need_ref only, REF_PIX=8 -> ref_rd_en high 8 cycles; ref_vld in cycle 10 with ref_in=0x0706050403020100; cur_rd_en never asserted.
- need_cur and need_ref both held, arb_mode=0 -> only cur bursts. Same stimulus with arb_mode=1 -> bursts alternate cur, ref, cur, ref.
- CUR_DEPTH=6, need_cur held -> first beat reads addrs 0..3; second beat reads 4,5,0,1, with cur_wrap pulsing on the addr-0 strobe.
- soft_clr pulsed in cycle 2 of a cur burst -> burst reads 0..3 unaffected; next cur burst restarts at addr 0.
- MEM_LAT=3, rst asserted in cycle 3 of a burst -> all outputs 0 immediately; no vld; after release the next burst starts at addr 0.
